// File: rtl/lift_pkg.sv
// Shared lift definitions: hall-call request codes, button indices, travel
// directions and the button-index/request-code translation helpers.
package lift_pkg;

    localparam int NUM_REQ = 6;

    localparam logic [2:0] C_NONE = 3'b000;
    localparam logic [2:0] C_1U   = 3'b001;
    localparam logic [2:0] C_2U   = 3'b010;
    localparam logic [2:0] C_3U   = 3'b011;
    localparam logic [2:0] C_2D   = 3'b110;
    localparam logic [2:0] C_3D   = 3'b111;
    localparam logic [2:0] C_4D   = 3'b100;

    localparam int B_1U = 0;
    localparam int B_2U = 1;
    localparam int B_3U = 2;
    localparam int B_2D = 3;
    localparam int B_3D = 4;
    localparam int B_4D = 5;

    typedef enum logic [1:0] {
        STAY = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } dir_e;

    function automatic logic [2:0] idx_to_code(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_1U;
            3'd1:    return C_2U;
            3'd2:    return C_3U;
            3'd3:    return C_2D;
            3'd4:    return C_3D;
            3'd5:    return C_4D;
            default: return C_NONE;
        endcase
    endfunction

    // Unknown codes (including C_NONE) map to an empty mask so nothing is cleared.
    function automatic logic [NUM_REQ-1:0] code_to_onehot(input logic [2:0] code);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        case (code)
            C_1U:    oh[B_1U] = 1'b1;
            C_2U:    oh[B_2U] = 1'b1;
            C_3U:    oh[B_3U] = 1'b1;
            C_2D:    oh[B_2D] = 1'b1;
            C_3D:    oh[B_3D] = 1'b1;
            C_4D:    oh[B_4D] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/lift_req_scheduler_if.sv
// Button/lift-FSM side signals of the request scheduler; the scheduler uses
// the slave view, whoever drives buttons and done uses the master view.
interface lift_req_scheduler_if #(
    parameter int PW = 3
);
    import lift_pkg::*;

    logic [NUM_REQ-1:0] btn;
    logic               done;
    logic [2:0]         req_code;
    logic               q_empty;
    logic [NUM_REQ-1:0] pend;
    logic [PW:0]        occ;

    modport master (
        output btn,
        output done,
        input  req_code,
        input  q_empty,
        input  pend,
        input  occ
    );

    modport slave (
        input  btn,
        input  done,
        output req_code,
        output q_empty,
        output pend,
        output occ
    );

endinterface

// File: rtl/lift_req_fifo.sv
// Small synchronous FIFO with occupancy count; the head entry is visible
// combinationally so the lift FSM can latch it on the pop edge.
module lift_req_fifo #(
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [PW:0]   occ_o,
    output logic          empty_o,
    output logic          full_o
);

    localparam logic [PW-1:0] LAST     = PW'(DEPTH - 1);
    localparam logic [PW:0]   FULL_OCC = (PW + 1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   occ_q, occ_d;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (occ_q == '0);
    assign full_o  = (occ_q == FULL_OCC);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    assign occ_o   = occ_q;

    // Explicit wrap keeps the pointers correct for non-power-of-two depths.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (do_push) begin
            wr_d = (wr_q == LAST) ? '0 : wr_q + PW'(1);
        end
        if (do_pop) begin
            rd_d = (rd_q == LAST) ? '0 : rd_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (PW + 1)'(1);
            2'b01:   occ_d = occ_q - (PW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/lift_req_scheduler.sv
// Hall-call scheduler: dedupes button presses, queues them first-come-first-
// served and hands the head request to the lift FSM whenever it is idle.
module lift_req_scheduler #(
    parameter int DEPTH = 8,
    parameter int PW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    lift_req_scheduler_if.slave  bus
);
    import lift_pkg::*;

    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] waiting_q, waiting_d;
    logic [NUM_REQ-1:0] pop_oh;
    logic [NUM_REQ-1:0] pend_kept;
    logic [NUM_REQ-1:0] accept;
    logic [NUM_REQ-1:0] push_oh;
    logic [NUM_REQ-1:0] push_mask;
    logic [2:0]         head;
    logic [2:0]         push_code;
    logic [PW:0]        occ;
    logic               empty;
    logic               full;
    logic               pop;
    logic               push;

    assign pop    = bus.done & ~empty;
    assign pop_oh = pop ? code_to_onehot(head) : '0;
    assign push   = (|waiting_q) & ~full;

    // A press of the code being popped this edge is a fresh request, so the
    // pop clears pend before the press is judged.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign pend_kept[gi] = pend_q[gi] & ~pop_oh[gi];
        assign accept[gi]    = bus.btn[gi] & ~pend_kept[gi];
        if (gi == 0) begin : g_first
            assign push_oh[gi] = waiting_q[gi];
        end else begin : g_rest
            assign push_oh[gi] = waiting_q[gi] & ~(|waiting_q[gi-1:0]);
        end
    end

    always_comb begin
        push_code = C_NONE;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_oh[i]) begin
                push_code = idx_to_code(3'(i));
            end
        end
    end

    assign push_mask = push ? push_oh : '0;
    assign pend_d    = pend_kept | accept;
    assign waiting_d = (waiting_q & ~push_mask) | accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            waiting_q <= '0;
        end else begin
            pend_q    <= pend_d;
            waiting_q <= waiting_d;
        end
    end

    lift_req_fifo #(
        .DEPTH (DEPTH),
        .PW    (PW),
        .DW    (3)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_code),
        .pop_i   (pop),
        .data_o  (head),
        .occ_o   (occ),
        .empty_o (empty),
        .full_o  (full)
    );

    assign bus.req_code = empty ? C_NONE : head;
    assign bus.q_empty  = empty;
    assign bus.pend     = pend_q;
    assign bus.occ      = occ;

endmodule

// File: tb/tb_lift_req_scheduler.sv
// Bench for lift_req_scheduler: a queue-based model of the hall-call rules is
// compared with the DUT every cycle, plus literal checks for directed cases.
module tb_lift_req_scheduler;

    logic clk;
    logic rst;
    int   errors    = 0;
    int   checks    = 0;
    bit   check_en  = 0;

    lift_req_scheduler_if #(.PW(3)) bus ();

    lift_req_scheduler #(
        .DEPTH (8),
        .PW    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state
    logic [2:0] code_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};
    logic [2:0] fifo_m [$];
    logic [5:0] pend_m = '0;
    logic [5:0] wait_m = '0;
    int         acc_cnt   = 0;
    int         dut_pops  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int code_to_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++) begin
            if (code_tab[i] == c) return i;
        end
        return -1;
    endfunction

    // One clock: drive inputs, update model at the edge, return at negedge.
    task automatic cyc(input logic [5:0] b, input logic d);
        logic       dut_pop;
        logic [2:0] dut_code;
        logic       m_pop;
        logic [2:0] m_code;
        int         idx;
        int         lo;
        bus.btn  = b;
        bus.done = d;
        dut_pop  = d && !rst && (bus.q_empty === 1'b0);
        dut_code = bus.req_code;
        @(posedge clk);
        m_pop  = 1'b0;
        m_code = 3'b000;
        if (rst) begin
            fifo_m.delete();
            pend_m   = '0;
            wait_m   = '0;
            acc_cnt  = 0;
            dut_pops = 0;
        end else begin
            if (d && fifo_m.size() > 0) begin
                m_pop  = 1'b1;
                m_code = fifo_m.pop_front();
                idx    = code_to_idx(m_code);
                pend_m[idx] = 1'b0;
            end
            if (wait_m != '0) begin
                lo = 0;
                for (int i = 5; i >= 0; i--) begin
                    if (wait_m[i]) lo = i;
                end
                fifo_m.push_back(code_tab[lo]);
                wait_m[lo] = 1'b0;
            end
            for (int i = 0; i < 6; i++) begin
                if (b[i] && !pend_m[i]) begin
                    pend_m[i] = 1'b1;
                    wait_m[i] = 1'b1;
                    acc_cnt++;
                end
            end
            if (dut_pop || m_pop) begin
                chk("pop_flag", 32'(dut_pop), 32'(m_pop));
                if (m_pop) chk("pop_code", 32'(dut_code), 32'(m_code));
            end
            if (dut_pop) dut_pops++;
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("q_empty", 32'(bus.q_empty), 32'(fifo_m.size() == 0));
            chk("req_code", 32'(bus.req_code), (fifo_m.size() > 0) ? 32'(fifo_m[0]) : 32'd0);
            chk("pend", 32'(bus.pend), 32'(pend_m));
            chk("occ", 32'(bus.occ), 32'(fifo_m.size()));
            chk("occ_bound", 32'(bus.occ <= 4'd6), 32'd1);
            $display("cyc t=%0t btn=%b done=%b occ=%0d req=%b pend=%b", $time,
                     bus.btn, bus.done, bus.occ, bus.req_code, bus.pend);
        end
    end

    initial begin
        rst      = 1'b1;
        bus.btn  = '0;
        bus.done = 1'b0;

        // Reset with every button held
        cyc(6'h3F, 1'b0);
        check_en = 1;
        cyc(6'h3F, 1'b0);
        rst = 1'b0;
        chk("rst_q_empty", 32'(bus.q_empty), 32'd1);
        chk("rst_req_code", 32'(bus.req_code), 32'd0);
        chk("rst_pend", 32'(bus.pend), 32'd0);
        chk("rst_occ", 32'(bus.occ), 32'd0);
        repeat (3) cyc(6'h00, 1'b0);
        chk("rst_no_entry", 32'(bus.occ), 32'd0);

        // Single request, pop when done rises
        cyc(6'b000100, 1'b0);
        chk("single_pend", 32'(bus.pend), 32'b000100);
        chk("single_occ0", 32'(bus.occ), 32'd0);
        cyc(6'h00, 1'b0);
        chk("single_occ1", 32'(bus.occ), 32'd1);
        chk("single_code", 32'(bus.req_code), 32'b011);
        cyc(6'h00, 1'b0);
        cyc(6'h00, 1'b1);
        chk("single_empty", 32'(bus.q_empty), 32'd1);
        chk("single_pend0", 32'(bus.pend), 32'd0);

        // Simultaneous presses enter in ascending index order
        cyc(6'b101001, 1'b0);
        cyc(6'h00, 1'b0);
        chk("sim_head1", 32'(bus.req_code), 32'b001);
        cyc(6'h00, 1'b0);
        cyc(6'h00, 1'b0);
        chk("sim_occ3", 32'(bus.occ), 32'd3);
        cyc(6'h00, 1'b1);
        chk("sim_head2", 32'(bus.req_code), 32'b110);
        cyc(6'h00, 1'b1);
        chk("sim_head3", 32'(bus.req_code), 32'b100);
        cyc(6'h00, 1'b1);
        chk("sim_empty", 32'(bus.q_empty), 32'd1);

        // Dedupe repeated presses
        cyc(6'b000010, 1'b0);
        cyc(6'h00, 1'b0);
        repeat (3) cyc(6'b000010, 1'b0);
        chk("dedupe_occ", 32'(bus.occ), 32'd1);
        cyc(6'h00, 1'b1);
        cyc(6'h00, 1'b0);
        chk("dedupe_served", 32'(bus.occ), 32'd0);

        // Re-press of the code being popped
        cyc(6'b010000, 1'b0);
        cyc(6'h00, 1'b0);
        chk("repress_head", 32'(bus.req_code), 32'b111);
        cyc(6'b010000, 1'b1);
        chk("repress_pend", 32'(bus.pend[4]), 32'd1);
        cyc(6'h00, 1'b0);
        chk("repress_occ", 32'(bus.occ), 32'd1);
        chk("repress_code", 32'(bus.req_code), 32'b111);
        cyc(6'h00, 1'b1);
        cyc(6'h00, 1'b0);

        // Push and pop together across pointer wrap
        for (int k = 0; k < 20; k++) begin
            cyc(6'(1 << (k % 6)) | (($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h00), 1'b1);
        end

        // Random traffic with one mid-run reset
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                rst = 1'b1;
                cyc(6'($urandom), 1'b1);
                rst = 1'b0;
            end else begin
                cyc(($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'h00,
                    1'($urandom_range(0, 2) == 0));
            end
        end

        repeat (20) cyc(6'h00, 1'b1);
        chk("drain_occ", 32'(bus.occ), 32'd0);
        chk("served_once", 32'(dut_pops), 32'(acc_cnt));

        check_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lift_req_scheduler.md
Name: lift_req_scheduler

Overview:
- Collects hall-call button presses: floor 1 up, 2 up, 3 up, 2 down, 3 down, 4 down.
- Deduplicates them and orders them first-come-first-served in a small FIFO.
- Presents one request code at a time to the lift FSM's 3-bit request input, together with its queue-empty flag.
- Pops a request on each cycle in which the lift reports done (idle) and the queue is non-empty. Sits between the button debouncers and the lift FSM.

Parameters:
- DEPTH, 8, FIFO entries; must be >= 6 (one per distinct request), so a legal configuration never overflows.
- PW, 3, pointer width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn  in  6  one-cycle press pulses. Bit order: [0]=1U, [1]=2U, [2]=3U, [3]=2D, [4]=3D, [5]=4D.
- done  in  1  lift FSM idle indication.
- req_code  out  3  head request code to lift FSM; 3'b000 when queue empty.
- q_empty  out  1  high when FIFO holds no entries; drives the lift FSM's qEmpty input.
- pend  out  6  requests accepted but not yet served (button lamp drive), same bit order as btn.
- occ  out  PW+1  current FIFO occupancy.

Behaviour:
- Code map (index->code): 0->3'b001, 1->3'b010, 2->3'b011, 3->3'b110, 4->3'b111, 5->3'b100.
- Reset (rst=1 at an edge) clears pend, the waiting bitmap, both FIFO pointers and occ. After that edge: q_empty=1, req_code=3'b000, pend=0, occ=0.
- Reset mid-operation discards all queued and pending requests; presses in the reset cycle are dropped.
- Acceptance stage, per bit i at each edge:
  - If btn[i]=1 and pend[i]=0 (after this cycle's pop clear), set pend[i] and wait[i].
  - If btn[i]=1 and pend[i]=1, ignore the press (dedupe).
- Enqueue stage, one push per cycle:
  - If wait!=0 and occ<DEPTH, push the code of the lowest set index of wait, then clear that wait bit.
  - Multiple simultaneous presses therefore enter the FIFO in ascending index order, one per cycle.
  - If full, wait is held with no loss. This is unreachable when DEPTH>=6; the bench asserts it never occurs.
- Pop:
  - pop = done & ~q_empty, evaluated combinationally.
  - At the edge, advance the read pointer and clear the pend bit of the popped code.
  - The lift FSM latches req_code on that same edge.
- Push and pop in the same cycle: occ unchanged, both pointers advance.
- A press of code X in the same cycle that X is popped: pend[X] is cleared by the pop and re-set by the press. X is re-queued, because the lift is serving the old request.
- Combinational outputs:
  - q_empty = (occ==0).
  - req_code = fifo[rd_ptr] when non-empty, else 3'b000.
  - The 3'b000 value is not a valid code, so the lift default path produces STAY.
- Latency:
  - A press sampled at edge t sets wait at edge t and pushes at edge t+1.
  - q_empty falls after edge t+1.
  - The earliest pop is at edge t+2 if done=1.
- Pointers wrap modulo DEPTH.
- occ never exceeds DEPTH and never underflows, since pop is gated by ~q_empty.
- done is not checked for glitches; it is a registered output of the lift FSM.

Decomposition:
- Shared package lift_pkg holds:
  - Request code constants (C_1U..C_4D, C_NONE=3'b000).
  - Button index constants.
  - Direction constants UP/DOWN/STAY, shared with the lift FSM.
  - An idx_to_code function.
- One natural sub-module: lift_req_fifo. It is a synchronous FIFO with push/pop/occ, parameterised by DEPTH and a data width of 3.
- The acceptance/priority logic stays in the top level.

Test Plan:
- Reset: assert rst with btn=6'h3F for 2 cycles, then release. Required: q_empty=1, req_code=000, pend=0, occ=0. No entry appears afterward from the presses made during reset.
- Single request, done=0: pulse btn[2] at edge t. Required: pend=6'b000100 after t; occ=1 and req_code=011 after t+1. Raise done at t+3: pop at that edge, q_empty=1, pend=0.
- Simultaneous presses with done=0: pulse btn=6'b101001. Required: three pushes on consecutive edges in order 001, 110, 100; occ reaches 3. Then with done=1, req_code sequence 001,110,100 on successive pops.
- Dedupe: press btn[1] three times while pend[1]=1. Required: occ stays 1 and only one 010 entry is served.
- Re-press on pop: with 111 at head and done=1, pulse btn[4] in the pop cycle. Required: pend[4] remains 1 and 111 is enqueued again one edge later (occ returns to 1).
- Push/pop same cycle plus wrap: hold done=1 and feed presses for 20 cycles cycling through all 6 buttons. Required: FIFO order is preserved across pointer wrap, occ is never > 6, and every accepted press is served exactly once.
